ball_engine: RTL and testbench

BALL_ENGINE -- requirements
Module: ball_engine

---
 rtl/ball_engine.sv | 192 +++++++++++++++++++
 tb/tb_ball_engine.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - diagonal ball stepper with brick/boundary reflection and hit reporting
// Define BALL_BOTTOM_WALL_EN to make the bottom row reflect instead of losing the ball.
module ball_engine #(
  parameter int ROWS      = 12,
  parameter int COLS      = 16,
  parameter int DIV       = 1,
  parameter int START_ROW = 9,
  parameter int START_COL = 9,
  parameter int START_DIR = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [ROWS*COLS-1:0]          data,
  input  logic                          tick,
  input  logic                          launch,
  output logic [$clog2(ROWS)-1:0]       ball_row,
  output logic [$clog2(COLS)-1:0]       ball_col,
  output logic [1:0]                    ball_dir,
  output logic [1:0]                    state,
  output logic                          hit_valid,
  output logic [$clog2(ROWS*COLS)-1:0]  hit_index,
  output logic                          lost
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int IW    = $clog2(ROWS*COLS);
  localparam int NCELL = ROWS * COLS;
  localparam int CNTW  = $clog2(DIV) + 1;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MOVE = 2'b01;
  localparam logic [1:0] S_LOST = 2'b10;

  logic [1:0]      state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [1:0]      dir_q, dir_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            hit_valid_q, hit_valid_d;
  logic [IW-1:0]   hit_index_q, hit_index_d;
  logic            lost_q, lost_d;

  int         cur_r, cur_c, dr, dc, diag_r, diag_c, nr, nc;
  logic       v_blk, h_blk, d_blk, dv_blk, dh_blk, diag_used, lost_cond;
  logic [1:0] res_dir;
  logic       hit;
  logic [IW-1:0] hit_idx;

  function automatic logic cell_out(input int rr, input int cc);
    return (rr < 0) || (rr >= ROWS) || (cc < 0) || (cc >= COLS);
  endfunction

  function automatic logic cell_occ(input int rr, input int cc, input logic [NCELL-1:0] map);
    if (cell_out(rr, cc)) return 1'b0;
    return map[rr*COLS+cc];
  endfunction

  function automatic logic cell_blk(input int rr, input int cc, input logic [NCELL-1:0] map);
    return cell_out(rr, cc) || cell_occ(rr, cc, map);
  endfunction

  // Direction bit 1 selects vertical motion (1 = down), bit 0 horizontal (1 = col+1).
  always_comb begin
    cur_r  = int'(row_q);
    cur_c  = int'(col_q);
    dr     = dir_q[1] ? 1 : -1;
    dc     = dir_q[0] ? 1 : -1;
    v_blk  = cell_blk(cur_r + dr, cur_c, data);
    h_blk  = cell_blk(cur_r, cur_c + dc, data);
    d_blk  = cell_blk(cur_r + dr, cur_c + dc, data);
    dv_blk = cell_blk(cur_r - dr, cur_c + dc, data);
    dh_blk = cell_blk(cur_r + dr, cur_c - dc, data);
    diag_used = 1'b0;
    diag_r    = cur_r + dr;
    diag_c    = cur_c + dc;
    res_dir   = dir_q;
    if (v_blk && h_blk) begin
      res_dir = dir_q ^ 2'b11;
    end else if (v_blk) begin
      res_dir = dv_blk ? (dir_q ^ 2'b11) : (dir_q ^ 2'b10);
      diag_used = dv_blk;
      diag_r    = cur_r - dr;
    end else if (h_blk) begin
      res_dir = dh_blk ? (dir_q ^ 2'b11) : (dir_q ^ 2'b01);
      diag_used = dh_blk;
      diag_c    = cur_c - dc;
    end else if (d_blk) begin
      res_dir   = dir_q ^ 2'b11;
      diag_used = 1'b1;
    end
    nr = cur_r + (res_dir[1] ? 1 : -1);
    nc = cur_c + (res_dir[0] ? 1 : -1);

    hit     = 1'b0;
    hit_idx = '0;
    if (cell_occ(cur_r + dr, cur_c, data)) begin
      hit     = 1'b1;
      hit_idx = IW'((cur_r + dr) * COLS + cur_c);
    end else if (cell_occ(cur_r, cur_c + dc, data)) begin
      hit     = 1'b1;
      hit_idx = IW'(cur_r * COLS + cur_c + dc);
    end else if (diag_used && cell_occ(diag_r, diag_c, data)) begin
      hit     = 1'b1;
      hit_idx = IW'(diag_r * COLS + diag_c);
    end
  end

`ifdef BALL_BOTTOM_WALL_EN
  assign lost_cond = 1'b0;
`else
  assign lost_cond = (int'(row_q) == ROWS - 1) && dir_q[1];
`endif

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    hit_valid_d = 1'b0;
    hit_index_d = hit_index_q;
    lost_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        row_d = RW'(START_ROW);
        col_d = CW'(START_COL);
        dir_d = 2'(START_DIR);
        if (launch) state_d = S_MOVE;
      end
      S_MOVE: begin
        if (tick) begin
          if (cnt_q == CNTW'(DIV - 1)) begin
            cnt_d = '0;
            if (lost_cond) begin
              lost_d  = 1'b1;
              state_d = S_LOST;
            end else begin
              dir_d       = res_dir;
              row_d       = RW'(nr);
              col_d       = CW'(nc);
              hit_valid_d = hit;
              if (hit) hit_index_d = hit_idx;
            end
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      S_LOST: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        row_d   = RW'(START_ROW);
        col_d   = CW'(START_COL);
        dir_d   = 2'(START_DIR);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      row_q       <= RW'(START_ROW);
      col_q       <= CW'(START_COL);
      dir_q       <= 2'(START_DIR);
      cnt_q       <= '0;
      hit_valid_q <= 1'b0;
      hit_index_q <= '0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      hit_valid_q <= hit_valid_d;
      hit_index_q <= hit_index_d;
      lost_q      <= lost_d;
    end
  end

  assign ball_row  = row_q;
  assign ball_col  = col_q;
  assign ball_dir  = dir_q;
  assign state     = state_q;
  assign hit_valid = hit_valid_q;
  assign hit_index = hit_index_q;
  assign lost      = lost_q;

endmodule

// File: tb/tb_ball_engine.sv
// tb/tb_ball_engine.sv - directed bench for ball_engine
// Expectations for the bottom-row case follow BALL_BOTTOM_WALL_EN.
module tb_ball_engine;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, tick, launch;
  logic [191:0] map [5];
  logic [3:0]   row [5];
  logic [3:0]   col [5];
  logic [1:0]   dir [5];
  logic [1:0]   st  [5];
  logic         hv  [5];
  logic         lo  [5];
  logic [7:0]   hi  [5];

  int checks = 0;
  int errors = 0;
  int exp_row [8] = '{9, 8, 8, 8, 7, 7, 7, 6};

  ball_engine u0 (
    .clock(clock), .reset(reset), .data(map[0]), .tick(tick), .launch(launch),
    .ball_row(row[0]), .ball_col(col[0]), .ball_dir(dir[0]), .state(st[0]),
    .hit_valid(hv[0]), .hit_index(hi[0]), .lost(lo[0]));

  ball_engine #(.DIV(3)) u1 (
    .clock(clock), .reset(reset), .data(map[1]), .tick(tick), .launch(launch),
    .ball_row(row[1]), .ball_col(col[1]), .ball_dir(dir[1]), .state(st[1]),
    .hit_valid(hv[1]), .hit_index(hi[1]), .lost(lo[1]));

  ball_engine #(.START_ROW(5), .START_COL(5), .START_DIR(0)) u2 (
    .clock(clock), .reset(reset), .data(map[2]), .tick(tick), .launch(launch),
    .ball_row(row[2]), .ball_col(col[2]), .ball_dir(dir[2]), .state(st[2]),
    .hit_valid(hv[2]), .hit_index(hi[2]), .lost(lo[2]));

  ball_engine #(.START_ROW(0), .START_COL(0), .START_DIR(0)) u3 (
    .clock(clock), .reset(reset), .data(map[3]), .tick(tick), .launch(launch),
    .ball_row(row[3]), .ball_col(col[3]), .ball_dir(dir[3]), .state(st[3]),
    .hit_valid(hv[3]), .hit_index(hi[3]), .lost(lo[3]));

  ball_engine #(.START_ROW(11), .START_COL(3), .START_DIR(3)) u4 (
    .clock(clock), .reset(reset), .data(map[4]), .tick(tick), .launch(launch),
    .ball_row(row[4]), .ball_col(col[4]), .ball_dir(dir[4]), .state(st[4]),
    .hit_valid(hv[4]), .hit_index(hi[4]), .lost(lo[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic l, input logic t);
    launch = l;
    tick   = t;
    @(posedge clock);
    #1;
    launch = 1'b0;
    tick   = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    tick   = 1'b0;
    launch = 1'b0;
    for (int i = 0; i < 5; i++) map[i] = '0;
    map[2][69] = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_row", row[0], 9);
    check("rst_col", col[0], 9);
    check("rst_dir", dir[0], 0);
    check("rst_state", st[0], 0);
    check("rst_hv", hv[0], 0);
    check("rst_hi", hi[0], 0);
    check("rst_lost", lo[0], 0);

    reset = 1'b1;
    step(1'b1, 1'b1);
    check("launch_state", st[0], 1);
    check("launch_tick_ignored_row", row[0], 9);
    check("launch_tick_ignored_col", col[0], 9);
    check("div3_state", st[1], 1);

    step(1'b0, 1'b1);
    check("free_row", row[0], 8);
    check("free_col", col[0], 8);
    check("free_dir", dir[0], 0);
    check("free_hv", hv[0], 0);
    check("brick_dir", dir[2], 2);
    check("brick_row", row[2], 6);
    check("brick_col", col[2], 4);
    check("brick_hv", hv[2], 1);
    check("brick_hi", hi[2], 69);
    check("corner_dir", dir[3], 3);
    check("corner_row", row[3], 1);
    check("corner_col", col[3], 1);
    check("corner_hv", hv[3], 0);
`ifdef BALL_BOTTOM_WALL_EN
    check("wall_dir", dir[4], 1);
    check("wall_row", row[4], 10);
    check("wall_col", col[4], 4);
    check("wall_lost", lo[4], 0);
    check("wall_state", st[4], 1);
`else
    check("lost_pulse", lo[4], 1);
    check("lost_state", st[4], 2);
    check("lost_row_held", row[4], 11);
    check("lost_col_held", col[4], 3);
`endif
    check("div3_tick1_row", row[1], 9);

    step(1'b1, 1'b0);
    check("launch_in_move_state", st[0], 1);
    check("no_tick_row", row[0], 8);
    check("hv_one_cycle", hv[2], 0);
    check("hi_hold", hi[2], 69);
`ifdef BALL_BOTTOM_WALL_EN
    check("wall_launch_ignored", st[4], 1);
`else
    check("lost_to_idle", st[4], 0);
    check("lost_pulse_end", lo[4], 0);
    check("idle_row", row[4], 11);
    check("idle_col", col[4], 3);
    check("idle_dir", dir[4], 3);
`endif

    for (int k = 2; k <= 9; k++) begin
      step(1'b0, 1'b1);
      check($sformatf("div3_tick%0d_row", k), row[1], exp_row[k-2]);
      check($sformatf("div3_tick%0d_col", k), col[1], exp_row[k-2]);
    end
    check("free_tick9_row", row[0], 0);
`ifndef BALL_BOTTOM_WALL_EN
    check("idle_ignores_tick", st[4], 0);
`endif

    #2;
    reset = 1'b0;
    #1;
    check("async_row", row[0], 9);
    check("async_col", col[0], 9);
    check("async_dir", dir[0], 0);
    check("async_state", st[0], 0);
    check("async_lost", lo[0], 0);
    check("async_hv", hv[0], 0);
    check("async_hi", hi[2], 0);
    check("async_div3_state", st[1], 0);

    reset = 1'b1;
    @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
